// File: rtl/regfile_read_arbiter_pkg.sv
// Shared definitions for the register-file read arbiter.
// Holds the word and index widths, the requester count, the FSM state type
// and a one-hot to index encoder used by the arbiter top.
package regfile_read_arbiter_pkg;

  localparam int unsigned DATA_W = 13;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned N_REQ  = 4;
  localparam int unsigned PTR_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  // Encode a one-hot requester vector into its index (0 when empty).
  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/regfile_read_arbiter_rr_pick4.sv
// rr_pick4: combinational 4-way round-robin search.
// Ports:
//   req   - eligible request vector
//   ptr   - index searched first; search order ptr, ptr+1, ptr+2, ptr+3 (mod 4)
//   grant - one-hot winner (all zero when nothing is requested)
//   any   - high when grant is non-zero
module rr_pick4
  import regfile_read_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic             any
);

  logic [PTR_W-1:0] idx;

  // First requester found walking forward from ptr wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int off = 0; off < int'(N_REQ); off++) begin
      idx = ptr + PTR_W'(off);
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter: shares one 8-way register-file read mux between four
// requesters using a two-state (IDLE/READ) FSM and round-robin arbitration.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   req        - per-requester read request, held until its ack
//   addr       - 3-bit register index per requester, bits [3i+2:3i]
//   rd_sel     - registered select for the register mux
//   rd_data    - mux output for rd_sel
//   ack        - registered one-hot, single-cycle completion pulse
//   rsp_data   - read word, valid with ack, held otherwise
//   busy       - high while a read is in flight (READ state)
module regfile_read_arbiter
  import regfile_read_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = regfile_read_arbiter_pkg::DATA_W,
  parameter int unsigned N_REQ  = regfile_read_arbiter_pkg::N_REQ
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*ADDR_W-1:0]  addr,
  output logic [ADDR_W-1:0]        rd_sel,
  input  logic [DATA_W-1:0]        rd_data,
  output logic [N_REQ-1:0]         ack,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     busy
);

  state_t            state, state_d;
  logic [PTR_W-1:0]  ptr, ptr_d;
  logic [PTR_W-1:0]  win, win_d;
  logic [ADDR_W-1:0] rd_sel_d;
  logic [N_REQ-1:0]  ack_d;
  logic [DATA_W-1:0] rsp_data_d;

  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  grant;
  logic              any;

  // A requester being acked this cycle has not yet dropped req; mask it.
  assign elig = req & ~ack;

  rr_pick4 u_pick (
    .req   (elig),
    .ptr   (ptr),
    .grant (grant),
    .any   (any)
  );

  // State register plus registered datapath/outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      win      <= '0;
      rd_sel   <= '0;
      ack      <= '0;
      rsp_data <= '0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      win      <= win_d;
      rd_sel   <= rd_sel_d;
      ack      <= ack_d;
      rsp_data <= rsp_data_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (any) state_d = READ;
      READ:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and latched winner.
  always_comb begin
    ptr_d      = ptr;
    win_d      = win;
    rd_sel_d   = rd_sel;
    ack_d      = '0;
    rsp_data_d = rsp_data;
    case (state)
      IDLE: begin
        if (any) begin
          win_d = onehot_to_idx(grant);
          for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant[i]) rd_sel_d = addr[i*ADDR_W +: ADDR_W];
          end
        end
      end
      READ: begin
        ack_d[win] = 1'b1;
        rsp_data_d = rd_data;
        ptr_d      = win + PTR_W'(1);
      end
      default: ;
    endcase
  end

  assign busy = (state == READ);

endmodule

// File: doc/regfile_read_arbiter.md
REGFILE_READ_ARBITER -- requirements
Module: regfile_read_arbiter

Interface
REQ-001 Parameter DATA_W, default 13, SHALL set the register-file word width.
REQ-002 Parameter N_REQ, default 4, SHALL set the requester count; only 4 SHALL be supported.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 req  input  4  SHALL carry per-requester read requests, held high until the matching ack.
REQ-006 addr  input  12  SHALL carry a 3-bit register index per requester, bits [3i+2:3i] for requester i, stable while req[i] is high.
REQ-007 rd_sel  output  3  SHALL drive the select inputs of the 8-way register mux, with bit 2 as MSB.
REQ-008 rd_data  input  DATA_W  SHALL carry the mux output for rd_sel.
REQ-009 ack  output  4  SHALL be a one-hot, one-cycle completion pulse per requester.
REQ-010 rsp_data  output  DATA_W  SHALL carry the read word, valid while any ack bit is high.
REQ-011 busy  output  1  SHALL be high while the FSM is in READ.

Function
REQ-012 The FSM SHALL have two states: IDLE and READ.
REQ-013 In IDLE, if any eligible req is high, the block SHALL pick a winner by round-robin from pointer ptr, latch winner id and addr, and enter READ on the next edge.
REQ-014 Round-robin SHALL search ptr, ptr+1, ptr+2, ptr+3 modulo 4; the first eligible req wins.
REQ-015 In IDLE with no eligible req, the block SHALL stay in IDLE, and rd_sel SHALL hold its last value.
REQ-016 In READ, rd_sel SHALL equal the latched addr, and rd_data SHALL be sampled into rsp_data at the closing edge.
REQ-017 At the READ closing edge, ack[winner] SHALL be set for exactly one cycle, ptr SHALL become (winner+1) mod 4, and the FSM SHALL return to IDLE.
REQ-018 Latency SHALL be fixed: req first high before edge k gives READ in cycle k+1 and ack/rsp_data in cycle k+2.
REQ-019 Peak throughput SHALL be one grant per 2 cycles; arbitration SHALL occur in the ack cycle.
REQ-020 In a cycle where ack[i] is high, req[i] SHALL be treated as ineligible, so a sole requester is not re-granted.
REQ-021 A req change during READ SHALL NOT alter the latched winner or address.
REQ-022 Simultaneous requests SHALL be resolved strictly by REQ-014; no requester waits more than 3 grants.
REQ-023 rsp_data SHALL hold its value when ack is 0.
REQ-024 ack SHALL never have more than one bit set.

Reset
REQ-025 Asserting rst_n low SHALL immediately force: state IDLE, ptr 0, rd_sel 0, ack 0, rsp_data 0, busy 0.
REQ-026 Reset during READ SHALL abort the read with no ack; the requester SHALL be re-arbitrated after release if req is still high.
REQ-027 The first edge after rst_n rises SHALL be able to perform arbitration.

Structure
REQ-028 A shared package SHALL hold DATA_W=13, ADDR_W=3, N_REQ=4, and the state type {IDLE, READ}.
REQ-029 The round-robin search SHALL be a combinational sub-module rr_pick4 (inputs req, ptr; outputs one-hot grant, any).
REQ-030 rd_sel and ack SHALL come directly from registers (no combinational path from req).

Verification
REQ-031 Single request: req=0001, addr0=5, mux word 5 = 0x0ABC -> rd_sel=5 in READ, then ack=0001 and rsp_data=0x0ABC two cycles after the request.
REQ-032 All four requesting after reset (ptr=0), distinct addrs -> ack order 0,1,2,3, spaced 2 cycles, each rsp_data matching its addr.
REQ-033 Sole requester 2 holding req one cycle past ack -> no second grant to 2; busy stays 0 in the ack cycle.
REQ-034 Reset pulsed mid-READ for requester 1 -> ack stays 0000, outputs zeroed, requester 1 served after release.
REQ-035 ptr=3, req=1001 -> requester 3 granted first, then requester 0.
REQ-036 addr changed during READ -> rsp_data reflects the originally latched addr.
